// File: rtl/timing_phase_monitor_pkg.sv
// Shared constants for the timing phase monitor: FSM encoding and bus widths.
package timing_phase_monitor_pkg;

  // Width of the binary phase index and of the one-hot timing bus.
  localparam int PHASE_W = 3;
  localparam int BUS_W   = 8;

  // FSM state encoding (2 bits).
  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

endpackage : timing_phase_monitor_pkg

// File: rtl/timing_phase_monitor_onehot8_enc.sv
// One-hot to binary encoder for the 8-bit timing bus.
// Phase p corresponds to bit 7-p, so idx = 7 - (position of the set bit).
module onehot8_enc
  import timing_phase_monitor_pkg::*;
(
  input  logic [BUS_W-1:0]   t_in,
  output logic [PHASE_W-1:0] idx,
  output logic               is_onehot
);

  logic [3:0] ones;

  // Count the set bits and record the phase index of the (last) set bit.
  always_comb begin
    ones = 4'd0;
    idx  = '0;
    for (int i = 0; i < BUS_W; i++) begin
      if (t_in[i]) begin
        ones = ones + 4'd1;
        idx  = PHASE_W'(BUS_W - 1 - i);
      end
    end
    is_onehot = (ones == 4'd1);
  end

endmodule : onehot8_enc

// File: rtl/timing_phase_monitor.sv
// Timing phase monitor: tracks a rotating one-hot timing bus, declares lock
// after LOCK_CNT consecutive valid advances, flags sequence violations while
// locked and counts completed rotations.
module timing_phase_monitor
  import timing_phase_monitor_pkg::*;
#(
  parameter int LOCK_CNT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [BUS_W-1:0]   t_in,
  input  logic               clr_err,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               locked,
  output logic               err,
  output logic               err_sticky,
  output logic [7:0]         rev_count
);

  localparam logic [2:0] LOCK_TARGET = 3'(LOCK_CNT);

  logic [PHASE_W-1:0] enc_idx;
  logic               enc_onehot;

  logic [1:0]         state_reg, state_next;
  logic [PHASE_W-1:0] prev_idx_reg, prev_idx_next;
  logic [2:0]         good_cnt_reg, good_cnt_next;
  logic [7:0]         rev_count_reg, rev_count_next;
  logic               err_next;
  logic               valid_adv;

  onehot8_enc u_enc (
    .t_in      (t_in),
    .idx       (enc_idx),
    .is_onehot (enc_onehot)
  );

  // A valid advance is a one-hot sample exactly one phase ahead (mod 8).
  assign valid_adv = enc_onehot && (enc_idx == PHASE_W'(prev_idx_reg + 3'd1));

  // Next-state logic for the lock FSM, advance tracking and rotation count.
  always_comb begin
    state_next     = state_reg;
    prev_idx_next  = prev_idx_reg;
    good_cnt_next  = good_cnt_reg;
    rev_count_next = rev_count_reg;
    err_next       = 1'b0;
    if (en) begin
      case (state_reg)
        ST_SEARCH: begin
          if (enc_onehot) begin
            prev_idx_next = enc_idx;
            good_cnt_next = 3'd0;
            state_next    = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (!enc_onehot) begin
            state_next = ST_SEARCH;
          end else if (valid_adv) begin
            prev_idx_next = enc_idx;
            good_cnt_next = good_cnt_reg + 3'd1;
            if (good_cnt_reg + 3'd1 == LOCK_TARGET) begin
              state_next = ST_LOCKED;
            end
          end else begin
            // One-hot but out of sequence: restart counting from here.
            prev_idx_next = enc_idx;
            good_cnt_next = 3'd0;
          end
        end
        ST_LOCKED: begin
          if (valid_adv) begin
            prev_idx_next = enc_idx;
            if (prev_idx_reg == 3'd7) begin
              rev_count_next = rev_count_reg + 8'd1;
            end
          end else begin
            err_next   = 1'b1;
            state_next = ST_SEARCH;
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end
  end

  // State and output registers; reset overrides enable and error clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_SEARCH;
      prev_idx_reg  <= '0;
      good_cnt_reg  <= 3'd0;
      rev_count_reg <= 8'd0;
      phase         <= '0;
      phase_valid   <= 1'b0;
      err           <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_idx_reg  <= prev_idx_next;
      good_cnt_reg  <= good_cnt_next;
      rev_count_reg <= rev_count_next;
      err           <= err_next;
      if (en) begin
        phase_valid <= enc_onehot;
        if (enc_onehot) begin
          phase <= enc_idx;
        end
      end
      // A new error wins over a simultaneous clear.
      if (err_next) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

  assign locked    = (state_reg == ST_LOCKED);
  assign rev_count = rev_count_reg;

endmodule : timing_phase_monitor

// File: tb/tb_timing_phase_monitor.sv
// Directed testbench for timing_phase_monitor with hand-computed expectations.
module tb_timing_phase_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] t_in;
  logic       clr_err;
  logic [2:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic [7:0] rev_count;

  int checks = 0;
  int errors = 0;

  timing_phase_monitor #(.LOCK_CNT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .t_in        (t_in),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .err         (err),
    .err_sticky  (err_sticky),
    .rev_count   (rev_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample and wait until just after the active edge.
  task automatic step(input logic e, input logic [7:0] t, input logic c);
    en      = e;
    t_in    = t;
    clr_err = c;
    @(posedge clk);
    #1;
    $display("t=%0t en=%0b t_in=%02h clr=%0b -> phase=%0d pv=%0b lk=%0b err=%0b stk=%0b rev=%0d",
             $time, e, t, c, phase, phase_valid, locked, err, err_sticky, rev_count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 8'h80, 1'b1);
    reset = 1'b0;
  endtask

  // Drive n successive ring samples starting at phase p0.
  task automatic ring(input int p0, input int n);
    logic [7:0] base;
    base = 8'h80;
    for (int k = 0; k < n; k++) begin
      step(1'b1, base >> ((p0 + k) % 8), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; t_in = 8'h00; clr_err = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_phase", 8'(phase), 8'd0);
    check("rst_pv", 8'(phase_valid), 8'd0);
    check("rst_locked", 8'(locked), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    check("rst_sticky", 8'(err_sticky), 8'd0);
    check("rst_rev", rev_count, 8'd0);

    // Lock-up: 80,40,20,10
    step(1'b1, 8'h80, 1'b0);
    check("lk1_phase", 8'(phase), 8'd0);
    check("lk1_pv", 8'(phase_valid), 8'd1);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    check("lk3_locked", 8'(locked), 8'd0);
    step(1'b1, 8'h10, 1'b0);
    check("lk4_locked", 8'(locked), 8'd1);
    check("lk4_phase", 8'(phase), 8'd3);

    // Skip while locked: 04 = phase 5
    step(1'b1, 8'h04, 1'b0);
    check("skip_err", 8'(err), 8'd1);
    check("skip_locked", 8'(locked), 8'd0);
    check("skip_sticky", 8'(err_sticky), 8'd1);
    check("skip_phase", 8'(phase), 8'd5);
    step(1'b0, 8'h00, 1'b0);
    check("skip_err_pulse", 8'(err), 8'd0);
    check("skip_sticky_hold", 8'(err_sticky), 8'd1);

    // Rotation count: 20 ring edges from 80
    do_reset();
    ring(0, 20);
    check("ring_rev", rev_count, 8'd2);
    check("ring_sticky", 8'(err_sticky), 8'd0);
    check("ring_locked", 8'(locked), 8'd1);
    check("ring_phase", 8'(phase), 8'd3);

    // Hold: en=0 for 5 cycles with garbage on the bus
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'hC3, 1'b0);
      check("hold_phase", 8'(phase), 8'd3);
      check("hold_pv", 8'(phase_valid), 8'd1);
      check("hold_locked", 8'(locked), 8'd1);
      check("hold_err", 8'(err), 8'd0);
      check("hold_rev", rev_count, 8'd2);
    end

    // Resume sequence after hold, then invalid bus 00
    step(1'b1, 8'h08, 1'b0);
    check("resume_locked", 8'(locked), 8'd1);
    check("resume_phase", 8'(phase), 8'd4);
    step(1'b1, 8'h00, 1'b0);
    check("inv00_pv", 8'(phase_valid), 8'd0);
    check("inv00_err", 8'(err), 8'd1);
    check("inv00_locked", 8'(locked), 8'd0);
    check("inv00_phase", 8'(phase), 8'd4);
    check("inv00_rev_kept", rev_count, 8'd2);
    step(1'b1, 8'h00, 1'b0);
    check("search_no_err", 8'(err), 8'd0);

    // Relock, then C0 with simultaneous clr_err: set wins
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    check("relock_locked", 8'(locked), 8'd1);
    step(1'b1, 8'hC0, 1'b1);
    check("c0_err", 8'(err), 8'd1);
    check("c0_pv", 8'(phase_valid), 8'd0);
    check("c0_phase", 8'(phase), 8'd3);
    check("c0_sticky_setwins", 8'(err_sticky), 8'd1);
    step(1'b1, 8'h80, 1'b1);
    check("clr_sticky", 8'(err_sticky), 8'd0);
    check("clr_err_zero", 8'(err), 8'd0);

    // Repeat while acquiring never errors; then reset mid-lock with rev_count=5
    do_reset();
    ring(0, 41);
    check("rev5_rev", rev_count, 8'd5);
    check("rev5_locked", 8'(locked), 8'd1);
    check("rev5_phase", 8'(phase), 8'd0);
    reset = 1'b1;
    step(1'b1, 8'h40, 1'b0);
    reset = 1'b0;
    check("midrst_locked", 8'(locked), 8'd0);
    check("midrst_rev", rev_count, 8'd0);
    check("midrst_phase", 8'(phase), 8'd0);
    check("midrst_pv", 8'(phase_valid), 8'd0);
    check("midrst_err", 8'(err), 8'd0);
    check("midrst_sticky", 8'(err_sticky), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_timing_phase_monitor
